pipeline_hazard_controller: RTL and testbench

- Central freeze/flush sequencer for the five-stage ARM pipeline.
- Drives the freeze/flush inputs of the IF-stage PC/instruction register and the downstream ID/EXE/MEM stage registers.
- Arbitrates between three events: multi-cycle SRAM access stalls (FSM plus wait counter), taken-branch flushes, and load-use data-hazard bubbles.
- Also keeps saturating stall and flush performance counters for debug.

---
 rtl/pipeline_hazard_controller_pkg.sv | 16 +
 rtl/saturating_counter.sv | 20 ++
 rtl/pipeline_hazard_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// default sizing of the SRAM wait and the debug performance counters.
package pipeline_hazard_controller_pkg;

   localparam int ADDRESS_LEN          = 32;
   localparam int SRAM_WAIT_CYCLES_DEF = 6;
   localparam int PERF_CNT_LEN_DEF     = 16;
   localparam int WAIT_CNT_LEN         = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for debug
// performance counters where a wrapped value would be misleading.
module saturating_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // count up on inc, hold once every bit is set
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Freeze/flush sequencer for the five-stage pipeline. A MEM-stage access
// freezes every stage for SRAM_WAIT_CYCLES cycles, a taken branch flushes
// IF/ID and ID/EXE, and a load-use hazard holds the front end while a bubble
// enters ID/EXE. Memory stalls win over branches, branches over hazards.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int SRAM_WAIT_CYCLES = SRAM_WAIT_CYCLES_DEF,
   parameter int PERF_CNT_LEN     = PERF_CNT_LEN_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hazard_in,
   input  logic                    branch_taken_in,
   input  logic                    mem_r_en_in,
   input  logic                    mem_w_en_in,
   output logic                    pc_freeze,
   output logic                    if_reg_freeze,
   output logic                    if_reg_flush,
   output logic                    id_reg_freeze,
   output logic                    id_reg_flush,
   output logic                    exe_reg_freeze,
   output logic                    mem_reg_freeze,
   output logic                    sram_start,
   output logic                    mem_ready,
   output logic [PERF_CNT_LEN-1:0] stall_count,
   output logic [PERF_CNT_LEN-1:0] flush_count
);

   // Stalled cycles still to come after the request cycle itself.
   localparam logic [WAIT_CNT_LEN-1:0] WAIT_LOAD = WAIT_CNT_LEN'(SRAM_WAIT_CYCLES - 1);

   mem_state_e              state, state_nxt;
   logic [WAIT_CNT_LEN-1:0] wait_cnt, wait_cnt_nxt;
   logic                    mem_req;
   logic                    mem_stall;
   logic                    start_raw;
   logic                    ready_raw;

   assign mem_req = mem_r_en_in | mem_w_en_in;

   // state and wait counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next state, stall and strobes. wait_cnt counts the stalled cycles left
   // after the current one, so MEM_WAIT leaves when it is on its last (cnt==1)
   // and a one-cycle access skips MEM_WAIT entirely.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_stall    = 1'b0;
      start_raw    = 1'b0;
      ready_raw    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req) begin
               start_raw    = 1'b1;
               mem_stall    = 1'b1;
               wait_cnt_nxt = WAIT_LOAD;
               state_nxt    = (WAIT_LOAD == '0) ? MEM_DONE : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            mem_stall    = 1'b1;
            wait_cnt_nxt = wait_cnt - WAIT_CNT_LEN'(1);
            if (wait_cnt <= WAIT_CNT_LEN'(1))
               state_nxt = MEM_DONE;
         end
         MEM_DONE: begin
            ready_raw = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // prioritised freeze/flush decode, forced quiet while in reset
   always_comb begin
      pc_freeze      = 1'b0;
      if_reg_freeze  = 1'b0;
      if_reg_flush   = 1'b0;
      id_reg_freeze  = 1'b0;
      id_reg_flush   = 1'b0;
      exe_reg_freeze = 1'b0;
      mem_reg_freeze = 1'b0;
      sram_start     = 1'b0;
      mem_ready      = 1'b0;
      if (!rst) begin
         sram_start = start_raw;
         mem_ready  = ready_raw;
         if (mem_stall) begin
            pc_freeze      = 1'b1;
            if_reg_freeze  = 1'b1;
            id_reg_freeze  = 1'b1;
            exe_reg_freeze = 1'b1;
            mem_reg_freeze = 1'b1;
         end else if (branch_taken_in) begin
            // branch discards the hazarding instruction, so it outranks hazard
            if_reg_flush = 1'b1;
            id_reg_flush = 1'b1;
         end else if (hazard_in) begin
            pc_freeze     = 1'b1;
            if_reg_freeze = 1'b1;
            id_reg_flush  = 1'b1;
         end
      end
   end

   saturating_counter #(.WIDTH(PERF_CNT_LEN)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_freeze),
      .count (stall_count)
   );

   saturating_counter #(.WIDTH(PERF_CNT_LEN)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_reg_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a default instance (6-cycle wait,
// 16-bit counters) and a small one (1-cycle wait, 4-bit counters) share the
// same stimulus and are checked against an access-age reference model.
module tb_pipeline_hazard_controller;

   logic clk = 1'b0;
   logic rst = 1'b0, hazard_in = 1'b0, branch_taken_in = 1'b0;
   logic mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;

   logic        pf0, ifz0, iff0, idz0, idf0, exz0, mmz0, st0, rdy0;
   logic [15:0] sc_o0, fc_o0;
   logic        pf1, ifz1, iff1, idz1, idf1, exz1, mmz1, st1, rdy1;
   logic [3:0]  sc_o1, fc_o1;

   always #5 clk = ~clk;

   pipeline_hazard_controller u_dut (
      .clk(clk), .rst(rst), .hazard_in(hazard_in), .branch_taken_in(branch_taken_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .pc_freeze(pf0), .if_reg_freeze(ifz0), .if_reg_flush(iff0),
      .id_reg_freeze(idz0), .id_reg_flush(idf0), .exe_reg_freeze(exz0),
      .mem_reg_freeze(mmz0), .sram_start(st0), .mem_ready(rdy0),
      .stall_count(sc_o0), .flush_count(fc_o0));

   pipeline_hazard_controller #(.SRAM_WAIT_CYCLES(1), .PERF_CNT_LEN(4)) u_sat (
      .clk(clk), .rst(rst), .hazard_in(hazard_in), .branch_taken_in(branch_taken_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .pc_freeze(pf1), .if_reg_freeze(ifz1), .if_reg_flush(iff1),
      .id_reg_freeze(idz1), .id_reg_flush(idf1), .exe_reg_freeze(exz1),
      .mem_reg_freeze(mmz1), .sram_start(st1), .mem_ready(rdy1),
      .stall_count(sc_o1), .flush_count(fc_o1));

   // {pc_frz, if_frz, if_flush, id_frz, id_flush, exe_frz, mem_frz, start, ready}
   wire [17:0] obs_out = {pf1, ifz1, iff1, idz1, idf1, exz1, mmz1, st1, rdy1,
                          pf0, ifz0, iff0, idz0, idf0, exz0, mmz0, st0, rdy0};
   wire [39:0] obs_cnt = {sc_o1, fc_o1, sc_o0, fc_o0};

   // Reference model: age = cycles since the access began (-1 when none).
   // Ages 0..W-1 are stalled, age W is the completion cycle.
   int W   [2] = '{6, 1};
   int MAX [2] = '{65535, 15};
   int age [2] = '{-1, -1};
   int sc  [2] = '{0, 0};
   int fc  [2] = '{0, 0};
   logic [8:0] exp_o [2];
   int passed = 0, total = 0;

   function automatic logic [8:0] model_out(int a, int w, logic r, logic h, logic b, logic req);
      logic start, stall, ready;
      logic [6:0] ff;
      if (r) return '0;
      start = (a < 0) && req;
      stall = start || (a >= 0 && a < w);
      ready = (a == w);
      if (stall)  ff = 7'b1101011;
      else if (b) ff = 7'b0010100;
      else if (h) ff = 7'b1100100;
      else        ff = 7'b0000000;
      return {ff, start, ready};
   endfunction

   function automatic int model_next_age(int a, int w, logic r, logic req);
      int e;
      if (r) return -1;
      e = (a < 0 && req) ? 0 : a;
      if (e < 0 || e >= w) return -1;
      return e + 1;
   endfunction

   function automatic logic [17:0] exp_out();
      return {exp_o[1], exp_o[0]};
   endfunction

   function automatic logic [39:0] exp_cnt();
      return {4'(sc[1]), 4'(fc[1]), 16'(sc[0]), 16'(fc[0])};
   endfunction

   // s = {rst, hazard, branch, rd, wr}; applied at negedge, expectations ready #1 later
   task automatic drive(input logic [4:0] s);
      @(negedge clk);
      {rst, hazard_in, branch_taken_in, mem_r_en_in, mem_w_en_in} = s;
      #1;
      for (int i = 0; i < 2; i++)
         exp_o[i] = model_out(age[i], W[i], rst, hazard_in, branch_taken_in,
                              mem_r_en_in | mem_w_en_in);
   endtask

   // clock edge: advance the model alongside the DUT
   task automatic advance();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            sc[i] = 0;
            fc[i] = 0;
         end else begin
            if (exp_o[i][8] && sc[i] < MAX[i]) sc[i]++;
            if (exp_o[i][6] && fc[i] < MAX[i]) fc[i]++;
         end
         age[i] = model_next_age(age[i], W[i], rst, mem_r_en_in | mem_w_en_in);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(5'b11111);
         total++;
         if (obs_out !== 18'd0) $display("FAIL reset_out cyc=%0d got=%b exp=0", c, obs_out);
         else passed++;
         advance();
      end
      drive(5'b00000);
      total++;
      if (obs_cnt !== 40'd0) $display("FAIL reset_cnt got=%h exp=0", obs_cnt);
      else passed++;
      total++;
      if (obs_out !== 18'd0) $display("FAIL reset_idle got=%b exp=0", obs_out);
      else passed++;
      advance();
   endtask

   task automatic test_single_load();
      int sc0 = sc_o0, starts = 0;
      for (int c = 0; c < 9; c++) begin
         drive(c == 0 ? 5'b00010 : 5'b00000);
         if (st0) starts++;
         total++;
         if (obs_out !== exp_out()) $display("FAIL load_out cyc=%0d got=%b exp=%b", c, obs_out, exp_out());
         else passed++;
         advance();
         total++;
         if (obs_cnt !== exp_cnt()) $display("FAIL load_cnt cyc=%0d got=%h exp=%h", c, obs_cnt, exp_cnt());
         else passed++;
      end
      total++;
      if (int'(sc_o0) - sc0 != 6 || starts != 1)
         $display("FAIL load_len stall_delta=%0d starts=%0d exp 6/1", int'(sc_o0) - sc0, starts);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int sc0 = sc_o0, starts = 0, readies = 0;
      for (int c = 0; c < 16; c++) begin
         drive(c == 0 ? 5'b00001 : (c == 7 ? 5'b00010 : 5'b00000));
         if (st0) starts++;
         if (rdy0) readies++;
         total++;
         if (obs_out !== exp_out()) $display("FAIL b2b_out cyc=%0d got=%b exp=%b", c, obs_out, exp_out());
         else passed++;
         advance();
         total++;
         if (obs_cnt !== exp_cnt()) $display("FAIL b2b_cnt cyc=%0d got=%h exp=%h", c, obs_cnt, exp_cnt());
         else passed++;
      end
      total++;
      if (int'(sc_o0) - sc0 != 12 || starts != 2 || readies != 2)
         $display("FAIL b2b_len stall_delta=%0d starts=%0d readies=%0d exp 12/2/2",
                  int'(sc_o0) - sc0, starts, readies);
      else passed++;
   endtask

   task automatic test_branch_hazard();
      int fc0 = fc_o0;
      drive(5'b01100);
      total++;
      if ({pf0, iff0, idf0} !== 3'b011 || obs_out !== exp_out())
         $display("FAIL br_hz_out got=%b exp=%b", obs_out, exp_out());
      else passed++;
      advance();
      total++;
      if (int'(fc_o0) - fc0 != 1) $display("FAIL br_hz_flush delta=%0d exp 1", int'(fc_o0) - fc0);
      else passed++;
      drive(5'b01000);
      total++;
      if ({pf0, ifz0, idf0, iff0} !== 4'b1110 || obs_out !== exp_out())
         $display("FAIL hz_out got=%b exp=%b", obs_out, exp_out());
      else passed++;
      advance();
      total++;
      if (obs_cnt !== exp_cnt()) $display("FAIL hz_cnt got=%h exp=%h", obs_cnt, exp_cnt());
      else passed++;
   endtask

   task automatic test_branch_in_stall();
      int fc0 = fc_o0;
      for (int c = 0; c < 9; c++) begin
         drive(c == 0 ? 5'b00010 : ((c >= 2 && c <= 6) ? 5'b00100 : 5'b00000));
         total++;
         if (obs_out !== exp_out() || (c < 6 && iff0 !== 1'b0) || (c == 6 && iff0 !== 1'b1))
            $display("FAIL br_stall_out cyc=%0d got=%b exp=%b", c, obs_out, exp_out());
         else passed++;
         advance();
      end
      total++;
      if (int'(fc_o0) - fc0 != 1 || obs_cnt !== exp_cnt())
         $display("FAIL br_stall_cnt flush_delta=%0d cnt=%h exp=%h", int'(fc_o0) - fc0, obs_cnt, exp_cnt());
      else passed++;
   endtask

   task automatic test_reset_mid();
      int readies = 0;
      for (int c = 0; c < 10; c++) begin
         drive(c == 0 ? 5'b00010 : (c == 3 ? 5'b10000 : 5'b00000));
         if (rdy0) readies++;
         total++;
         if (obs_out !== exp_out()) $display("FAIL rst_mid_out cyc=%0d got=%b exp=%b", c, obs_out, exp_out());
         else passed++;
         advance();
      end
      total++;
      if (readies != 0 || obs_cnt !== exp_cnt())
         $display("FAIL rst_mid readies=%0d cnt=%h exp 0/%h", readies, obs_cnt, exp_cnt());
      else passed++;
   endtask

   task automatic test_random();
      logic [4:0] s;
      for (int c = 0; c < 400; c++) begin
         s[4] = ($urandom_range(0, 39) == 0);
         s[3] = ($urandom_range(0, 3) == 0);
         s[2] = ($urandom_range(0, 4) == 0);
         s[1] = ($urandom_range(0, 5) == 0);
         s[0] = ($urandom_range(0, 5) == 0);
         drive(s);
         total++;
         if (obs_out !== exp_out()) $display("FAIL rand_out cyc=%0d in=%b got=%b exp=%b", c, s, obs_out, exp_out());
         else passed++;
         advance();
         total++;
         if (obs_cnt !== exp_cnt()) $display("FAIL rand_cnt cyc=%0d got=%h exp=%h", c, obs_cnt, exp_cnt());
         else passed++;
      end
   endtask

   task automatic test_saturation();
      drive(5'b10000);
      advance();
      for (int c = 0; c < 20; c++) begin
         drive(5'b01000);
         advance();
      end
      total++;
      if (sc_o1 !== 4'd15 || sc_o0 !== 16'd20)
         $display("FAIL saturate small=%0d big=%0d exp 15/20", sc_o1, sc_o0);
      else passed++;
      total++;
      if (obs_cnt !== exp_cnt()) $display("FAIL saturate_cnt got=%h exp=%h", obs_cnt, exp_cnt());
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_back_to_back();
      test_branch_hazard();
      test_branch_in_stall();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
